// File: rtl/quad_pkg.sv
// Shared types and the Gray-code move decoder for the quadrature receiver.
package quad_pkg;

    localparam logic [1:0] ST_00 = 2'b00;
    localparam logic [1:0] ST_01 = 2'b01;
    localparam logic [1:0] ST_11 = 2'b11;
    localparam logic [1:0] ST_10 = 2'b10;

    typedef enum logic {PRIME, RUN} fsm_t;

    typedef enum logic [1:0] {MV_NONE, MV_UP, MV_DOWN, MV_ILLEGAL} move_t;

    // Forward order is 00->01->11->10->00; any single-bit change not in that
    // order is a reverse step, a double-bit change cannot be attributed.
    function automatic move_t decode_move(input logic [1:0] prev, input logic [1:0] cur);
        move_t mv;
        mv = MV_NONE;
        if (prev == cur) begin
            mv = MV_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            mv = MV_ILLEGAL;
        end else if ((prev == ST_00 && cur == ST_01) ||
                     (prev == ST_01 && cur == ST_11) ||
                     (prev == ST_11 && cur == ST_10) ||
                     (prev == ST_10 && cur == ST_00)) begin
            mv = MV_UP;
        end else begin
            mv = MV_DOWN;
        end
        return mv;
    endfunction

endpackage

// File: rtl/quad_sync.sv
// N-stage synchronizer for one asynchronous input bit, cleared by async reset.
module quad_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/quad_decoder.sv
// Quadrature A/B receiver: step pulses, direction, wrapping position count, sticky err.
// Define QUAD_INDEX_EN to add the quad_z index input and the index_seen flag.
module quad_decoder
    import quad_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
`ifdef QUAD_INDEX_EN
    input  logic             quad_z,
`endif
    input  logic             enable,
    input  logic             clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             step,
    output logic             dir,
`ifdef QUAD_INDEX_EN
    output logic             index_seen,
`endif
    output logic             err
);

    localparam int PW = $clog2(SYNC_STAGES + 1);

    logic        syncA;
    logic        syncB;
    logic [1:0]  curAb;
    logic [1:0]  prevAb;
    logic [PW-1:0] primeCnt;
    fsm_t        state;
    move_t       move;

    quad_sync #(.STAGES(SYNC_STAGES)) uSyncA (.clk(clk), .reset(reset), .d(quad_a), .q(syncA));
    quad_sync #(.STAGES(SYNC_STAGES)) uSyncB (.clk(clk), .reset(reset), .d(quad_b), .q(syncB));

`ifdef QUAD_INDEX_EN
    logic syncZ;
    logic zPrev;

    quad_sync #(.STAGES(SYNC_STAGES)) uSyncZ (.clk(clk), .reset(reset), .d(quad_z), .q(syncZ));
`endif

    assign curAb = {syncA, syncB};
    assign move  = decode_move(prevAb, curAb);

    // PRIME waits until the synchronizers hold a real pin sample before
    // adopting it as the reference, so the pin state at release never looks
    // like a transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PRIME;
            primeCnt <= '0;
            prevAb   <= ST_00;
            count    <= '0;
            step     <= 1'b0;
            dir      <= 1'b1;
            err      <= 1'b0;
`ifdef QUAD_INDEX_EN
            zPrev      <= 1'b0;
            index_seen <= 1'b0;
`endif
        end else begin
            step <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end

            case (state)
                PRIME: begin
                    if (primeCnt < PW'(SYNC_STAGES)) begin
                        primeCnt <= primeCnt + 1'b1;
                    end else begin
                        prevAb <= curAb;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    prevAb <= curAb;
                    case (move)
                        MV_UP: begin
                            if (enable) begin
                                step  <= 1'b1;
                                dir   <= 1'b1;
                                count <= count + CNT_W'(1);
                            end
                        end
                        MV_DOWN: begin
                            if (enable) begin
                                step  <= 1'b1;
                                dir   <= 1'b0;
                                count <= count - CNT_W'(1);
                            end
                        end
                        MV_ILLEGAL: begin
                            err <= 1'b1;
                        end
                        default: begin
                        end
                    endcase
                end
                default: begin
                    state <= PRIME;
                end
            endcase

            if (clr) begin
                count <= '0;
            end

`ifdef QUAD_INDEX_EN
            // The index pulse re-references the count and outranks any step
            // landing in the same cycle.
            zPrev <= syncZ;
            if (clr) begin
                index_seen <= 1'b0;
            end
            if (state == RUN && syncZ && !zPrev) begin
                count      <= '0;
                index_seen <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_quad_decoder.sv
// Directed self-checking bench for quad_decoder (CNT_W=4 so both wraps are short).
module tb_quad_decoder;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             quad_a;
    logic             quad_b;
    logic             enable;
    logic             clr;
    logic             err_clr;
    logic [CNT_W-1:0] count;
    logic             step;
    logic             dir;
    logic             err;
`ifdef QUAD_INDEX_EN
    logic             quad_z;
    logic             index_seen;
`endif

    int         compared   = 0;
    int         mismatched = 0;
    int         stepCount  = 0;
    int         base;
    logic [1:0] curAb;

    quad_decoder #(.CNT_W(CNT_W), .SYNC_STAGES(2)) dut (
        .clk(clk),
        .reset(reset),
        .quad_a(quad_a),
        .quad_b(quad_b),
`ifdef QUAD_INDEX_EN
        .quad_z(quad_z),
        .index_seen(index_seen),
`endif
        .enable(enable),
        .clr(clr),
        .err_clr(err_clr),
        .count(count),
        .step(step),
        .dir(dir),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (step === 1'b1) stepCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic logic [1:0] grayUp(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] grayDn(input logic [1:0] ab);
        case (ab)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Drive a pin state and wait until its effect has settled (3 edges).
    task automatic applyStimulus(input logic [1:0] ab);
        @(negedge clk);
        {quad_a, quad_b} = ab;
        curAb = ab;
        repeat (3) @(negedge clk);
    endtask

    task automatic stepUp(input int n);
        for (int i = 0; i < n; i++) applyStimulus(grayUp(curAb));
    endtask

    task automatic stepDown(input int n);
        for (int i = 0; i < n; i++) applyStimulus(grayDn(curAb));
    endtask

    task automatic pulseClr();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; clr = 1'b0; err_clr = 1'b0;
        {quad_a, quad_b} = 2'b11; curAb = 2'b11;
`ifdef QUAD_INDEX_EN
        quad_z = 1'b0;
`endif
        repeat (3) @(negedge clk);
        checkOutput("rst_count", 32'(count), 0);
        checkOutput("rst_step", 32'(step), 0);
        checkOutput("rst_dir", 32'(dir), 1);
        checkOutput("rst_err", 32'(err), 0);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        checkOutput("prime_steps", 32'(stepCount), 0);
        checkOutput("prime_count", 32'(count), 0);
        checkOutput("prime_err", 32'(err), 0);

        // 11->10, checking the two-edge synchronizer latency
        @(negedge clk); {quad_a, quad_b} = 2'b10; curAb = 2'b10;
        @(negedge clk);
        @(negedge clk);
        checkOutput("latency_early", 32'(step), 0);
        @(negedge clk);
        checkOutput("first_step", 32'(step), 1);
        checkOutput("first_dir", 32'(dir), 1);
        checkOutput("first_count", 32'(count), 1);

        pulseClr();
        checkOutput("clr_count", 32'(count), 0);
        base = stepCount;
        stepUp(8);
        checkOutput("fwd8_steps", 32'(stepCount - base), 8);
        checkOutput("fwd8_count", 32'(count), 8);
        checkOutput("fwd8_dir", 32'(dir), 1);
        stepDown(4);
        checkOutput("rev4_count", 32'(count), 4);
        checkOutput("rev4_dir", 32'(dir), 0);

        pulseClr();
        base = stepCount;
        stepDown(1);
        checkOutput("wrap_down", 32'(count), 15);
        stepUp(17);
        checkOutput("wrap_up", 32'(count), 0);
        checkOutput("wrap_dir", 32'(dir), 1);
        checkOutput("wrap_steps", 32'(stepCount - base), 18);

        base = stepCount;
        applyStimulus(curAb ^ 2'b11);
        checkOutput("illegal_err", 32'(err), 1);
        checkOutput("illegal_count", 32'(count), 0);
        checkOutput("illegal_steps", 32'(stepCount - base), 0);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        checkOutput("errclr", 32'(err), 0);
        // err_clr lands on the same edge as a second illegal jump
        @(negedge clk); {quad_a, quad_b} = curAb ^ 2'b11; curAb = curAb ^ 2'b11;
        @(negedge clk);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 0;
        checkOutput("errclr_vs_illegal", 32'(err), 1);
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;

        stepUp(2);
        stepDown(1);
        checkOutput("pre_mask_count", 32'(count), 1);
        enable = 1'b0;
        base = stepCount;
        stepUp(3);
        checkOutput("mask_steps", 32'(stepCount - base), 0);
        checkOutput("mask_count", 32'(count), 1);
        checkOutput("mask_dir", 32'(dir), 0);
        enable = 1'b1;
        stepUp(1);
        checkOutput("unmask_count", 32'(count), 2);
        checkOutput("unmask_dir", 32'(dir), 1);

        @(negedge clk); {quad_a, quad_b} = grayDn(curAb); curAb = grayDn(curAb);
        @(negedge clk);
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        checkOutput("clr_step_count", 32'(count), 0);
        checkOutput("clr_step_step", 32'(step), 1);
        checkOutput("clr_step_dir", 32'(dir), 0);

        stepUp(3);
        applyStimulus(curAb ^ 2'b11);
        checkOutput("pre_reset_err", 32'(err), 1);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_count", 32'(count), 0);
        checkOutput("async_rst_dir", 32'(dir), 1);
        checkOutput("async_rst_err", 32'(err), 0);
        {quad_a, quad_b} = 2'b11; curAb = 2'b11;
        @(negedge clk); reset = 1'b0;
        base = stepCount;
        repeat (8) @(negedge clk);
        checkOutput("reprime_steps", 32'(stepCount - base), 0);
        checkOutput("reprime_err", 32'(err), 0);
        stepUp(1);
        checkOutput("reprime_count", 32'(count), 1);

`ifdef QUAD_INDEX_EN
        stepUp(4);
        checkOutput("idx_pre_count", 32'(count), 5);
        checkOutput("idx_pre_seen", 32'(index_seen), 0);
        @(negedge clk); quad_z = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("idx_count", 32'(count), 0);
        checkOutput("idx_seen", 32'(index_seen), 1);
        quad_z = 1'b0;
        stepUp(2);
        // index edge and step reach the FSM together; index wins the count
        @(negedge clk); quad_z = 1'b1; {quad_a, quad_b} = grayUp(curAb); curAb = grayUp(curAb);
        repeat (3) @(negedge clk);
        checkOutput("idx_vs_step_count", 32'(count), 0);
        checkOutput("idx_vs_step_step", 32'(step), 1);
        pulseClr();
        checkOutput("idx_clr_seen", 32'(index_seen), 0);
        quad_z = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
